if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
Instruction fetch unit; the initiator that drives the instruction memory's word-addressed, combinational-read port.
- Holds the PC and presents it on im_addr.
- Captures im_data together with its PC into a 2-entry buffer.
- Hands {pc, instr} to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush, plus fault detection for misaligned or out-of-range PCs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
NMEM, 34, number of valid instruction words; legal PCs are 0 .. 4*NMEM-4.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
im_addr  output  32  byte address to instruction memory; always equals current PC register
im_data  input  32  instruction word returned combinationally for im_addr
out_valid  output  1  buffer head holds a valid instruction
out_ready  input  1  decode accepts head this cycle
out_instr  output  32  instruction at buffer head
out_pc  output  32  PC of instruction at buffer head
redirect_valid  input  1  branch/jump taken; load redirect_pc and flush
redirect_pc  input  32  redirect target byte address
fault  output  1  fetch stopped on bad PC
fault_pc  output  32  offending PC latched at fault entry
fetch_count  output  32  number of instructions accepted by decode (pop count)

Behaviour:
- Reset (async, rst=1) sets:
  - pc=RESET_PC, buffer count=0, rd/wr pointers=0;
  - out_valid=0, out_instr=0, out_pc=0;
  - fault=0, fault_pc=0, fetch_count=0;
  - state=RUN.
  - Any in-flight content is discarded.
- States: RUN, FAULT.
- im_addr = pc at all times. No wait states: im_data is sampled in the same cycle.
- pop = out_valid & out_ready. push = state==RUN & !redirect_valid & pc legal & (count<2 | pop).
- On push: write {pc, im_data} at wr pointer; pc <= pc+4.
- Buffer:
  - 2-entry circular buffer.
  - push and pop in the same cycle leaves count unchanged; this includes when full.
  - out_valid = (count!=0); out_instr/out_pc are driven from the rd-pointer entry.
  - When empty, out_instr/out_pc hold their last value.
- Legal PC: pc[1:0]==0 and pc[31:2] <= NMEM-1.
- RUN with illegal pc (and no redirect):
  - go to FAULT, fault<=1, fault_pc<=pc;
  - no push; already-buffered entries still drain normally.
- FAULT: no pushes; pc holds; fault stays high until redirect.
- Redirect has highest priority, in RUN or FAULT:
  - count<=0 and pointers reset; the same-cycle pop is ignored and fetch_count is not incremented.
  - pc<=redirect_pc; no push that cycle.
  - If redirect_pc is legal: state<=RUN, fault<=0.
  - Else: state<=FAULT, fault<=1, fault_pc<=redirect_pc.
  - Fetch from the target begins the following cycle, so out_valid can rise 2 cycles after the redirect edge at the earliest.
- Latency: instruction at pc is visible on out_* one cycle after pc is presented, when the buffer was empty.
- Steady state, out_ready=1: one instruction per cycle.
- fetch_count increments on every non-flushed pop; wraps modulo 2^32.
- PC arithmetic: 32-bit; pc+4 wrap past 2^32 is irrelevant because it is caught earlier as out-of-range.
- pc legality is checked on the registered pc, not on pc+4; fault is reported on the cycle the bad pc is presented.

Decomposition:
- Shared package:
  - IF_WORD_BYTES=4;
  - state encoding localparams IF_RUN / IF_FAULT;
  - a packed fetch-entry type {pc[31:0], instr[31:0]} reused by the decode stage.
- One sub-module is natural: if_fetch_buf, a 2-deep, 64-bit-wide buffer with push/pop/flush and count. The PC/state logic stays in if_fetch.

Test Plan:
- Reset then out_ready=1, memory word k = 32'h1000_0000+k -> out_valid rises cycle 1; out_pc = 0,4,8,... and out_instr = 32'h1000_0000, 32'h1000_0001,... one per cycle; fetch_count=N after N pops.
- Back-pressure: out_ready=0 for 5 cycles from reset -> count saturates at 2, im_addr holds 8; release -> PCs 0,4,8 delivered in order with no loss or duplication.
- Redirect mid-stream with buffer full: redirect_valid=1, redirect_pc=32'h40 with out_ready=1 -> same-cycle pop not counted, out_valid=0 next cycle; next delivered out_pc=32'h40.
- Run off end with NMEM=34: reaching pc=32'h88 -> fault=1, fault_pc=32'h88; last delivered out_pc=32'h84; no further pushes.
- Misaligned redirect_pc=32'h22 -> fault=1, fault_pc=32'h22; a following redirect to 32'h10 clears fault, and fetch resumes at 32'h10.
- Assert rst mid-stream with buffer full -> out_valid=0, fault=0, fetch_count=0 immediately; im_addr=RESET_PC, and fetch restarts after rst deasserts.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage types: state encoding, fetch-entry layout and PC legality helper.
package if_fetch_pkg;

  localparam int unsigned IF_WORD_BYTES = 4;

  typedef enum logic {
    IF_RUN   = 1'b0,
    IF_FAULT = 1'b1
  } if_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;

  // A PC is fetchable when word aligned and inside the populated memory.
  function automatic logic pc_legal(input logic [31:0] pc, input int unsigned nmem);
    return (pc[1:0] == 2'b00) && (pc[31:2] <= 30'(nmem - 1));
  endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// Two-entry circular buffer of fetch entries with push/pop/flush; head holds its last value when empty.
module if_fetch_buf
  import if_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  if_entry_t wdata,
  output if_entry_t head,
  output logic      valid,
  output logic [1:0] count
);

  if_entry_t  mem_reg [2];
  if_entry_t  last_reg;
  logic       rd_ptr_reg, wr_ptr_reg;
  logic [1:0] count_reg, count_next;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          mem_reg[gi] <= '0;
        else if (push && !flush && (wr_ptr_reg == 1'(gi)))
          mem_reg[gi] <= wdata;
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = 2'd0;
    else if (push && !pop)
      count_next = count_reg + 2'd1;
    else if (pop && !push)
      count_next = count_reg - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      last_reg   <= '0;
    end else begin
      count_reg <= count_next;
      // Remember what decode last saw so an empty buffer keeps showing it.
      if (count_reg != 2'd0)
        last_reg <= mem_reg[rd_ptr_reg];
      if (flush) begin
        rd_ptr_reg <= 1'b0;
        wr_ptr_reg <= 1'b0;
      end else begin
        if (push) wr_ptr_reg <= ~wr_ptr_reg;
        if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

  assign valid = (count_reg != 2'd0);
  assign count = count_reg;
  assign head  = valid ? mem_reg[rd_ptr_reg] : last_reg;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC/state control driving a combinational-read instruction memory into a 2-entry buffer.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NMEM     = 34
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  if_state_t   state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] fault_pc_reg, fault_pc_next;
  logic [31:0] fetch_count_reg, fetch_count_next;
  logic        pop, push, buf_pop;
  logic [1:0]  buf_count;
  if_entry_t   head, wdata;

  assign pop     = out_valid & out_ready;
  assign buf_pop = pop & ~redirect_valid;
  assign push    = (state_reg == IF_RUN) && !redirect_valid && pc_legal(pc_reg, NMEM)
                   && ((buf_count < 2'd2) || pop);
  assign wdata   = '{pc: pc_reg, instr: im_data};

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    fault_pc_next    = fault_pc_reg;
    fetch_count_next = fetch_count_reg;
    if (redirect_valid) begin
      pc_next = redirect_pc;
      if (pc_legal(redirect_pc, NMEM)) begin
        state_next = IF_RUN;
      end else begin
        state_next    = IF_FAULT;
        fault_pc_next = redirect_pc;
      end
    end else begin
      if (pop)
        fetch_count_next = fetch_count_reg + 32'd1;
      if (push)
        pc_next = pc_reg + 32'(IF_WORD_BYTES);
      // Bad PC is caught on the cycle it is presented, never pre-emptively on pc+4.
      if (state_reg == IF_RUN && !pc_legal(pc_reg, NMEM)) begin
        state_next    = IF_FAULT;
        fault_pc_next = pc_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IF_RUN;
      pc_reg          <= RESET_PC;
      fault_pc_reg    <= '0;
      fetch_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      fault_pc_reg    <= fault_pc_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  if_fetch_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (buf_pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .head  (head),
    .valid (out_valid),
    .count (buf_count)
  );

  assign im_addr     = pc_reg;
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign fault       = (state_reg == IF_FAULT);
  assign fault_pc    = fault_pc_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized self-checking bench for if_fetch against a queue-based behavioural fetch model.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned NMEM     = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] im_addr, im_data;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr, out_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fault;
  logic [31:0] fault_pc, fetch_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_fault_pc, m_cnt;
  logic        m_fault;
  logic [63:0] m_q[$];
  logic [63:0] m_last;

  always #5 clk = ~clk;

  assign im_data = 32'h1000_0000 + (im_addr >> 2);

  if_fetch #(.RESET_PC(RESET_PC), .NMEM(NMEM)) dut (
    .clk(clk), .rst(rst), .im_addr(im_addr), .im_data(im_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < NMEM);
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_fault = 1'b0; m_fault_pc = '0; m_cnt = '0;
    m_q.delete(); m_last = '0;
  endtask

  task automatic model_step();
    bit do_pop;
    do_pop = (m_q.size() > 0) && out_ready;
    if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc;
      m_fault = !legal(redirect_pc);
      if (m_fault) m_fault_pc = redirect_pc;
    end else begin
      if (do_pop) begin
        void'(m_q.pop_front());
        m_cnt++;
      end
      if (!m_fault) begin
        if (!legal(m_pc)) begin
          m_fault = 1'b1;
          m_fault_pc = m_pc;
        end else if (m_q.size() < 2) begin
          m_q.push_back({m_pc, 32'h1000_0000 + m_pc / 4});
          m_pc += 4;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] shown;
    shown = (m_q.size() > 0) ? m_q[0] : m_last;
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    check("out_pc", out_pc, shown[63:32]);
    check("out_instr", out_instr, shown[31:0]);
    check("im_addr", im_addr, m_pc);
    check("fault", 32'(fault), 32'(m_fault));
    check("fault_pc", fault_pc, m_fault_pc);
    check("fetch_count", fetch_count, m_cnt);
    m_last = shown;
    $display("t=%0t rdy=%0b redir=%0b/%08h valid=%0b pc=%08h instr=%08h im=%08h fault=%0b cnt=%0d",
             $time, out_ready, redirect_valid, redirect_pc, out_valid, out_pc, out_instr,
             im_addr, fault, fetch_count);
  endtask

  // One clock: inputs already stable, model advances on the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      out_ready = rdy; redirect_valid = 1'b0;
      step();
    end
  endtask

  task automatic redirect(input logic [31:0] tgt, input logic rdy);
    out_ready = rdy; redirect_valid = 1'b1; redirect_pc = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    #2 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    @(negedge clk); rst = 1'b0;
    #4;

    // Back-pressure from reset, then release.
    run(5, 1'b0);
    check("bp_im_addr", im_addr, 32'h8);
    run(4, 1'b1);

    // Redirect with a full buffer.
    run(3, 1'b0);
    redirect(32'h40, 1'b1);
    run(6, 1'b1);

    // Run off the end of memory.
    run(30, 1'b1);
    check("end_fault_pc", fault_pc, 32'h88);
    check("end_last_pc", out_pc, 32'h84);

    // Misaligned redirect, then recovery.
    redirect(32'h22, 1'b1);
    check("mis_fault_pc", fault_pc, 32'h22);
    run(3, 1'b1);
    redirect(32'h10, 1'b1);
    run(4, 1'b1);

    // Async reset with a full buffer.
    run(3, 1'b0);
    mid_reset();
    run(4, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 9);
      if (r < 7)       redirect_pc = 32'($urandom_range(0, NMEM - 1)) * 4;
      else if (r == 7) redirect_pc = 32'($urandom_range(0, NMEM - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (r == 8) redirect_pc = 32'($urandom_range(NMEM, NMEM + 30)) * 4;
      else             redirect_pc = 32'($urandom_range(NMEM - 4, NMEM - 1)) * 4;
      step();
      if ($urandom_range(0, 499) == 0) mid_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
